// File: rtl/decode_queue.sv
// RV32I decode stage: DEPTH-entry {instr, pc} queue feeding a registered decoder on its head.
// Latency: a push at edge N is visible at the output after edge N+1 when the output stage is free.
// Backpressure: in_ready drops at full; the output holds while !out_ready, or while an illegal bundle is trap-held.
module decode_queue #(
  parameter int DEPTH      = 4,
  parameter int REG_BITS   = 5,
  parameter int TRAP_STALL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [REG_BITS-1:0]      rs1,
  output logic [REG_BITS-1:0]      rs2,
  output logic [REG_BITS-1:0]      rd,
  output logic [31:0]              imm,
  output logic [9:0]               func,
  output logic                     en_jmp,
  output logic                     en_uncond_jmp,
  output logic                     en_rel_reg_jmp,
  output logic                     en_imm,
  output logic                     en_reg_wr,
  output logic                     en_mem_wr,
  output logic                     en_mem_re,
  output logic [2:0]               ld_code,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Writeback source codes
  localparam logic [2:0] NO_LD     = 3'd0;
  localparam logic [2:0] LD_ALU    = 3'd1;
  localparam logic [2:0] LD_MEM    = 3'd2;
  localparam logic [2:0] LD_IMM    = 3'd3;
  localparam logic [2:0] LD_PC     = 3'd4;
  localparam logic [2:0] LD_PC_IMM = 3'd5;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, load, held;
  logic [31:0]   h;
  logic [2:0]    f3;
  logic [6:0]    f7;

  logic [31:0] d_imm;
  logic [9:0]  d_func;
  logic [2:0]  d_ld;
  logic        d_jmp, d_unc, d_rel, d_en_imm, d_reg_wr, d_mem_wr, d_mem_re, d_ill;

  // A sticky illegal bundle blocks further loads until flush or reset.
  assign held     = (TRAP_STALL != 0) && out_valid && illegal;
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign load     = (count != '0) && (!out_valid || out_ready) && !held;

  assign h  = instr_mem[rd_ptr];
  assign f3 = h[14:12];
  assign f7 = h[31:25];

  // Queue storage; a push in a flush cycle is dropped by the pointer logic, so writing is harmless.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  // Pointers and occupancy; power-of-two depth makes the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(load);
    end
  end

  // Combinational RV32I decode of the queue head, with illegal bundles squashed to a neutral form.
  always_comb begin
    d_imm    = '0;
    d_func   = {f7, f3};
    d_ld     = NO_LD;
    d_jmp    = 1'b0;
    d_unc    = 1'b0;
    d_rel    = 1'b0;
    d_en_imm = 1'b0;
    d_reg_wr = 1'b0;
    d_mem_wr = 1'b0;
    d_mem_re = 1'b0;
    d_ill    = 1'b0;
    case (h[6:0])
      7'b0110111: begin
        d_imm = {h[31:12], 12'b0}; d_ld = LD_IMM; d_reg_wr = 1'b1;
      end
      7'b0010111: begin
        d_imm = {h[31:12], 12'b0}; d_ld = LD_PC_IMM; d_reg_wr = 1'b1;
      end
      7'b1101111: begin
        d_imm = {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};
        d_ld = LD_PC; d_jmp = 1'b1; d_unc = 1'b1; d_en_imm = 1'b1; d_reg_wr = 1'b1;
      end
      7'b1100111: begin
        d_imm = {{20{h[31]}}, h[31:20]};
        d_ld = LD_PC; d_jmp = 1'b1; d_rel = 1'b1; d_en_imm = 1'b1; d_reg_wr = 1'b1;
        d_ill = (f3 != 3'b000);
      end
      7'b0000011: begin
        d_imm = {{20{h[31]}}, h[31:20]}; d_func = '0;
        d_ld = LD_MEM; d_en_imm = 1'b1; d_reg_wr = 1'b1; d_mem_re = 1'b1;
        d_ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0100011: begin
        d_imm = {{20{h[31]}}, h[31:25], h[11:7]}; d_func = '0;
        d_en_imm = 1'b1; d_mem_wr = 1'b1;
        d_ill = (f3 > 3'b010);
      end
      7'b1100011: begin
        d_imm = {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
        d_jmp = 1'b1;
        d_ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b0010011: begin
        d_imm = {{20{h[31]}}, h[31:20]};
        d_ld = LD_ALU; d_en_imm = 1'b1; d_reg_wr = 1'b1;
        if (f3 != 3'b001 && f3 != 3'b101) d_func = {7'b0, f3};
      end
      7'b0110011: begin
        d_ld = LD_ALU; d_reg_wr = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_imm    = '0;
      d_ld     = NO_LD;
      d_jmp    = 1'b0;
      d_unc    = 1'b0;
      d_rel    = 1'b0;
      d_en_imm = 1'b0;
      d_reg_wr = 1'b0;
      d_mem_wr = 1'b0;
      d_mem_re = 1'b0;
    end
  end

  // Output register: loads on pop, empties when consumed, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      rs1            <= '0;
      rs2            <= '0;
      rd             <= '0;
      imm            <= '0;
      func           <= '0;
      ld_code        <= NO_LD;
      en_jmp         <= 1'b0;
      en_uncond_jmp  <= 1'b0;
      en_rel_reg_jmp <= 1'b0;
      en_imm         <= 1'b0;
      en_reg_wr      <= 1'b0;
      en_mem_wr      <= 1'b0;
      en_mem_re      <= 1'b0;
      illegal        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid      <= 1'b1;
      out_pc         <= pc_mem[rd_ptr];
      rs1            <= REG_BITS'(h[19:15]);
      rs2            <= REG_BITS'(h[24:20]);
      rd             <= REG_BITS'(h[11:7]);
      imm            <= d_imm;
      func           <= d_func;
      ld_code        <= d_ld;
      en_jmp         <= d_jmp;
      en_uncond_jmp  <= d_unc;
      en_rel_reg_jmp <= d_rel;
      en_imm         <= d_en_imm;
      en_reg_wr      <= d_reg_wr;
      en_mem_wr      <= d_mem_wr;
      en_mem_re      <= d_mem_re;
      illegal        <= d_ill;
    end else if (out_ready && !held) begin
      out_valid <= 1'b0;
    end
  end
endmodule
